stream_word_packer: RTL
=======================

// Module: stream_word_packer
// PURPOSE
// - Write-side feeder for the byte-write simple-dual-port RAM. Packs a narrow valid/ready stream into
//   DATA_WIDTH words, drives wr_enable/wr_address/wr_data/wr_strb directly into the RAM write port.
// - Treats the RAM as a circular word buffer; stalls the stream when the consumer's read pointer shows it full.
// - Partial words (frame end, optional timeout) are committed with a reduced byte strobe.
// PARAMETERS
// - DATA_WIDTH    32  RAM word width in bits; multiple of IN_WIDTH
// - IN_WIDTH      8   stream beat width in bits; multiple of 8
// - ADDR_DEPTH    16  RAM depth in words; power of 2, >=2
// - ADDR_WIDTH    32  RAM byte-address width
// - FLUSH_TIMEOUT 64  idle cycles before a partial word is flushed (used only with STREAM_PACK_TIMEOUT_EN)
// - Derived: RATIO=DATA_WIDTH/IN_WIDTH, ADDR_LSB=$clog2(DATA_WIDTH/8), PTR_W=$clog2(ADDR_DEPTH)+1
// PORTS
// - wr_clk      in  1             single clock for the whole block
// - wr_rst      in  1             asynchronous, active-high reset
// - s_valid     in  1             stream beat valid
// - s_ready     out 1             stream beat accepted when s_valid&&s_ready
// - s_data      in  IN_WIDTH      stream beat payload
// - s_last      in  1             last beat of frame
// - rd_ptr      in  PTR_W         consumer word pointer (wr_clk domain, extra wrap bit)
// - wr_enable   out 1             RAM write enable
// - wr_address  out ADDR_WIDTH    RAM byte address, low ADDR_LSB bits zero
// - wr_data     out DATA_WIDTH    RAM write data
// - wr_strb     out DATA_WIDTH/8  RAM byte strobes
// - wr_ptr      out PTR_W         committed-word pointer (to consumer)
// - frame_done  out 1             one-cycle pulse with the write that ends a frame
// - frame_words out PTR_W         words committed in that frame, valid with frame_done
// BEHAVIOUR
// - Reset: all outputs 0 (s_ready 0 while wr_rst high, 1 from first clock after release), lane=0, state IDLE.
//   Reset mid-word discards the partial word; nothing is written.
// - used = wr_ptr - rd_ptr (mod 2^PTR_W). s_ready = (used < ADDR_DEPTH); registered-state only, no s_valid path.
// - Beat k of a word (k=0..RATIO-1, little-endian) -> data bits [k*IN_WIDTH+:IN_WIDTH], strb bits [k*IN_WIDTH/8+:IN_WIDTH/8].
// - FSM: IDLE (lane=0) -> FILL on accepted beat that neither completes the word nor has s_last.
//   FILL -> IDLE on commit. Commit = accepted beat at lane RATIO-1, or accepted beat with s_last, or timeout.
// - Commit latency: registered outputs; wr_enable=1 for exactly one cycle, the cycle after the committing beat.
//   wr_address = {wr_ptr[PTR_W-2:0], ADDR_LSB'b0} zero-extended. Unfilled lanes: data 0, strb 0.
//   wr_ptr increments in the same cycle wr_enable asserts; wraps naturally at 2^PTR_W (address wraps at ADDR_DEPTH).
// - s_last on a full-word beat: single write, full strobe; no extra empty write. s_last alone never writes an empty word.
// - frame_done pulses with the write that carries s_last; frame_words = words written since previous frame_done,
//   including this one; counter clears after the pulse.
// - Full: a beat may be accepted only while used<ADDR_DEPTH; when a commit makes used==ADDR_DEPTH, s_ready drops next cycle.
//   rd_ptr advance re-raises s_ready the cycle after it is seen.
// - Precondition: rd_ptr never passes wr_ptr; violation is undefined.
// CONFIGURATION
// - STREAM_PACK_TIMEOUT_EN defined: in FILL, an idle counter counts cycles without an accepted beat;
//   reaching FLUSH_TIMEOUT commits the partial word (frame_done not asserted).
//   An accepted beat in the same cycle wins and resets the counter.
// - Undefined: no counter; a partial word waits indefinitely for more beats or s_last.
// STRUCTURE
// - Package stream_pack_pkg: state enum typedef (IDLE, FILL), lane index/pointer width helper functions.
// - Optional sub-module pack_flush_timer (idle counter + expiry pulse), instantiated only under STREAM_PACK_TIMEOUT_EN.
//   Everything else stays in one module.
// TESTING (DATA_WIDTH=32, IN_WIDTH=8, ADDR_DEPTH=4, rd_ptr=0 unless stated)
// - Beats 11,22,33,44, no last -> next cycle wr_enable=1, wr_address=0, wr_data=0x44332211, wr_strb=4'b1111, wr_ptr=1.
// - Beats AA, BB(last) -> wr_data=0x0000BBAA, wr_strb=4'b0011, frame_done=1, frame_words=1.
// - 16 beats back-to-back -> writes at addresses 0,4,8,12; s_ready=0 after 4th; set rd_ptr=1 -> s_ready=1 next cycle;
//   next word written at address 0, wr_ptr=5.
// - 3 beats then wr_rst pulse -> no write, outputs 0; next 4 beats written at address 0 with full strobe.
// - Macro on, FLUSH_TIMEOUT=8: one beat 5A then idle -> write strb 4'b0001, data 0x0000005A after 8 idle cycles, frame_done=0;
//   macro off -> no write.

Source files
------------

// File: rtl/stream_pack_pkg.sv
// Shared types and width helpers for the stream word packer.
// Optional flush timeout is enabled with STREAM_PACK_TIMEOUT_EN.
package stream_pack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

  function automatic int lane_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pack_flush_timer.sv
// Idle counter for a partially filled word; pulses expire when it times out.
// Instantiated only when STREAM_PACK_TIMEOUT_EN is defined.
module pack_flush_timer #(
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic wr_clk,
  input  logic wr_rst,
  input  logic active,
  input  logic beat,
  output logic expire
);

  localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt;

  assign expire = active && !beat &&
                  (idle_cnt == CNT_W'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      idle_cnt <= '0;
    end else if (!active || beat || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stream_word_packer.sv
// Packs a narrow valid/ready stream into RAM words written as a circular buffer.
// Define STREAM_PACK_TIMEOUT_EN to flush idle partial words after FLUSH_TIMEOUT.
module stream_word_packer
  import stream_pack_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int IN_WIDTH      = 8,
  parameter int ADDR_DEPTH    = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int FLUSH_TIMEOUT = 64,
  localparam int PTR_W        = ptr_w(ADDR_DEPTH)
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_WIDTH-1:0]     s_data,
  input  logic                    s_last,
  input  logic [PTR_W-1:0]        rd_ptr,
  output logic                    wr_enable,
  output logic [ADDR_WIDTH-1:0]   wr_address,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic [PTR_W-1:0]        wr_ptr,
  output logic                    frame_done,
  output logic [PTR_W-1:0]        frame_words
);

  localparam int RATIO    = DATA_WIDTH / IN_WIDTH;
  localparam int BPB      = IN_WIDTH / 8;
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int LANE_W   = lane_w(RATIO);

  pack_state_e         state;
  logic [LANE_W-1:0]   lane;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [STRB_W-1:0]   acc_strb;
  logic [PTR_W-1:0]    frm_cnt;
  logic                ready_q;

  logic                beat;
  logic                last_lane;
  logic                commit;
  logic                expire;
  logic [PTR_W-1:0]    wr_ptr_nxt;
  logic [PTR_W-1:0]    used_nxt;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [STRB_W-1:0]   nxt_strb;

  assign s_ready    = ready_q;
  assign beat       = s_valid && ready_q;
  assign last_lane  = (lane == LANE_W'(RATIO - 1));
  assign commit     = (beat && (last_lane || s_last)) || expire;
  assign wr_ptr_nxt = wr_ptr + PTR_W'(commit);
  assign used_nxt   = wr_ptr_nxt - rd_ptr;

`ifdef STREAM_PACK_TIMEOUT_EN
  pack_flush_timer #(
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_flush_timer (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .active(state == FILL),
    .beat  (beat),
    .expire(expire)
  );
`else
  // timeout can never fire in this build
  assign expire = (FLUSH_TIMEOUT < 0);
`endif

  // an idle packer starts from an empty word
  always_comb begin
    nxt_data = (state == FILL) ? acc_data : '0;
    nxt_strb = (state == FILL) ? acc_strb : '0;
    if (beat) begin
      nxt_data[int'(lane)*IN_WIDTH +: IN_WIDTH] = s_data;
      nxt_strb[int'(lane)*BPB +: BPB]           = '1;
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state       <= IDLE;
      lane        <= '0;
      acc_data    <= '0;
      acc_strb    <= '0;
      frm_cnt     <= '0;
      ready_q     <= 1'b0;
      wr_enable   <= 1'b0;
      wr_address  <= '0;
      wr_data     <= '0;
      wr_strb     <= '0;
      wr_ptr      <= '0;
      frame_done  <= 1'b0;
      frame_words <= '0;
    end else begin
      ready_q     <= (used_nxt < PTR_W'(ADDR_DEPTH));
      wr_enable   <= commit;
      wr_ptr      <= wr_ptr_nxt;
      frame_done  <= beat && s_last;
      frame_words <= '0;
      if (commit) begin
        wr_address <= ADDR_WIDTH'(wr_ptr[PTR_W-2:0]) << ADDR_LSB;
        wr_data    <= nxt_data;
        wr_strb    <= nxt_strb;
        lane       <= '0;
        state      <= IDLE;
        if (beat && s_last) begin
          frame_words <= frm_cnt + 1'b1;
          frm_cnt     <= '0;
        end else begin
          frm_cnt <= frm_cnt + 1'b1;
        end
      end else if (beat) begin
        acc_data <= nxt_data;
        acc_strb <= nxt_strb;
        lane     <= lane + 1'b1;
        state    <= FILL;
      end
    end
  end

endmodule
